// File: rtl/qspi_framebuffer_responder.sv
// Framebuffer memory responder: decodes the 8-bit control bus, keeps independent
// read/write pointers into a 4-bit pixel store and repeats each source line on read.
module qspi_framebuffer_responder #(
   parameter int unsigned DEPTH          = 76800,
   parameter int unsigned READS_PER_LINE = 320,
   parameter int unsigned LINE_REPEAT    = 2,
   parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            ctrl_data_in,
   output logic [3:0]            data_out,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [ADDR_WIDTH-1:0] rd_addr_out,
   output logic                  write_overflow_out
);

   localparam int unsigned CNT_W = (READS_PER_LINE > 1) ? $clog2(READS_PER_LINE) : 1;
   localparam int unsigned REP_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_W-1:0]      LAST_READ = CNT_W'(READS_PER_LINE - 1);
   localparam logic [REP_W-1:0]      LAST_REP  = REP_W'(LINE_REPEAT - 1);

   logic                  rd_req, rd_rst, wr_rst, wr_strobe;
   logic [3:0]            wr_nibble;
   logic                  write_prev, wr_edge;

   logic [ADDR_WIDTH-1:0] wr_ptr, wr_base, wr_ptr_nxt;
   logic                  wr_full, wr_full_base, wr_full_nxt;
   logic                  overflow, overflow_base, overflow_nxt;

   logic [ADDR_WIDTH-1:0] rd_ptr, rd_base, rd_ptr_nxt;
   logic [ADDR_WIDTH-1:0] line_start, ls_base, line_start_nxt;
   logic [CNT_W-1:0]      read_cnt, cnt_base, read_cnt_nxt;
   logic [REP_W-1:0]      rep_cnt, rep_base, rep_cnt_nxt;

   logic [3:0]            mem [DEPTH];

   function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   assign rd_req    = ctrl_data_in[7];
   assign rd_rst    = ctrl_data_in[6];
   assign wr_rst    = ctrl_data_in[5];
   assign wr_strobe = ctrl_data_in[4];
   assign wr_nibble = ctrl_data_in[3:0];
   assign wr_edge   = wr_strobe && !write_prev;

   // Pointer resets take effect first so a same-cycle access sees the reset pointer.
   always_comb begin
      wr_base       = wr_rst ? '0   : wr_ptr;
      wr_full_base  = wr_rst ? 1'b0 : wr_full;
      overflow_base = wr_rst ? 1'b0 : overflow;
      wr_ptr_nxt    = wr_base;
      wr_full_nxt   = wr_full_base;
      overflow_nxt  = overflow_base;
      if (wr_edge) begin
         wr_ptr_nxt = addr_inc(wr_base);
         if (wr_full_base)
            overflow_nxt = 1'b1;
         if (wr_base == LAST_ADDR)
            wr_full_nxt = 1'b1;
      end
   end

   // Line-repeat read addressing: replay a source line, then step to the next one.
   always_comb begin
      rd_base        = rd_rst ? '0 : rd_ptr;
      ls_base        = rd_rst ? '0 : line_start;
      cnt_base       = rd_rst ? '0 : read_cnt;
      rep_base       = rd_rst ? '0 : rep_cnt;
      rd_ptr_nxt     = rd_base;
      line_start_nxt = ls_base;
      read_cnt_nxt   = cnt_base;
      rep_cnt_nxt    = rep_base;
      if (rd_req) begin
         if (cnt_base != LAST_READ) begin
            rd_ptr_nxt   = addr_inc(rd_base);
            read_cnt_nxt = cnt_base + CNT_W'(1);
         end else if (rep_base != LAST_REP) begin
            rd_ptr_nxt   = ls_base;
            read_cnt_nxt = '0;
            rep_cnt_nxt  = rep_base + REP_W'(1);
         end else begin
            rd_ptr_nxt     = addr_inc(rd_base);
            line_start_nxt = addr_inc(rd_base);
            read_cnt_nxt   = '0;
            rep_cnt_nxt    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_prev <= 1'b0;
         wr_ptr     <= '0;
         wr_full    <= 1'b0;
         overflow   <= 1'b0;
         rd_ptr     <= '0;
         line_start <= '0;
         read_cnt   <= '0;
         rep_cnt    <= '0;
         data_out   <= '0;
      end else begin
         write_prev <= wr_strobe;
         wr_ptr     <= wr_ptr_nxt;
         wr_full    <= wr_full_nxt;
         overflow   <= overflow_nxt;
         rd_ptr     <= rd_ptr_nxt;
         line_start <= line_start_nxt;
         read_cnt   <= read_cnt_nxt;
         rep_cnt    <= rep_cnt_nxt;
         if (rd_req)
            data_out <= mem[rd_base];
      end
   end

   // Pixel store is not reset; the non-blocking write gives read-before-write on collision.
   always_ff @(posedge clk) begin
      if (rst_n && wr_edge)
         mem[wr_base] <= wr_nibble;
   end

   assign wr_addr_out        = wr_ptr;
   assign rd_addr_out        = rd_ptr;
   assign write_overflow_out = overflow;

endmodule

// File: tb/tb_qspi_framebuffer_responder.sv
// Scoreboard bench for qspi_framebuffer_responder: random control traffic checked
// against a count-based reference model of pointers, line repeat and overflow.
module tb_qspi_framebuffer_responder;

   localparam int unsigned DEPTH = 12;
   localparam int unsigned RPL   = 4;
   localparam int unsigned LR    = 2;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    ctrl = 8'h00;
   logic [3:0]    data_out;
   logic [AW-1:0] wr_addr_out;
   logic [AW-1:0] rd_addr_out;
   logic          write_overflow_out;

   qspi_framebuffer_responder #(
      .DEPTH(DEPTH), .READS_PER_LINE(RPL), .LINE_REPEAT(LR), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_data_in(ctrl), .data_out(data_out),
      .wr_addr_out(wr_addr_out), .rd_addr_out(rd_addr_out),
      .write_overflow_out(write_overflow_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    data;
      logic [AW-1:0] rd;
      logic [AW-1:0] wr;
      logic          ovf;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: state is just counts of reads/writes since the last pointer reset.
   logic [3:0] mem_m [DEPTH];
   int         nreads = 0;
   int         nwrites = 0;
   bit         wprev = 0;
   logic [3:0] dout_m = 4'h0;

   function automatic int rd_addr_of(input int n);
      return ((n / (RPL * LR)) * RPL + n % RPL) % DEPTH;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [7:0] c);
      exp_t e;
      @(negedge clk);
      ctrl = c;
      if (c[6]) nreads = 0;
      if (c[7]) begin
         dout_m = mem_m[rd_addr_of(nreads)];
         nreads++;
      end
      if (c[5]) nwrites = 0;
      if (c[4] && !wprev) begin
         mem_m[nwrites % DEPTH] = c[3:0];
         nwrites++;
      end
      wprev = c[4];
      e.data = dout_m;
      e.rd   = AW'(rd_addr_of(nreads));
      e.wr   = AW'(nwrites % DEPTH);
      e.ovf  = (nwrites > int'(DEPTH));
      sb.push_back(e);
   endtask

   task automatic wr(input logic [3:0] d);
      step({4'b0001, d});
      step(8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ctrl  = 8'($urandom);
      #1;
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_rd_addr", 32'(rd_addr_out), 32'd0);
      check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
      check("rst_ovf", 32'(write_overflow_out), 32'd0);
      dout_m = 4'h0; nreads = 0; nwrites = 0; wprev = 0;
      repeat (2) begin
         @(negedge clk);
         ctrl = 8'($urandom);
      end
      @(negedge clk);
      ctrl  = 8'h00;
      rst_n = 1'b1;
   endtask

   // Monitor: one expected entry per active edge issued by the driver.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("data_out", 32'(data_out), 32'(e.data));
         check("rd_addr_out", 32'(rd_addr_out), 32'(e.rd));
         check("wr_addr_out", 32'(wr_addr_out), 32'(e.wr));
         check("write_overflow_out", 32'(write_overflow_out), 32'(e.ovf));
      end
   end

   initial begin
      logic [31:0] r;
      do_reset();

      // Fill the whole store, then read it back through the line-repeat sequence.
      step(8'h20);
      for (int i = 0; i < int'(DEPTH); i++) wr(4'($urandom));
      step(8'h40);
      for (int i = 0; i < int'(2 * DEPTH); i++) step(8'h80);
      for (int i = 0; i < int'(RPL * LR * 2); i++) begin
         step(8'h80);
         step(8'h00);
      end

      // Held strobe performs a single write.
      repeat (5) step(8'h1A);
      step(8'h00);

      // Overflow: DEPTH writes fill, one more overflows, pointer reset clears.
      step(8'h20);
      for (int i = 0; i < int'(DEPTH); i++) wr(4'($urandom));
      wr(4'h9);
      step(8'h20);

      // Collisions: reset_read with read, and read/write on the same address.
      step(8'hC0);
      step(8'h40);
      step(8'h95);
      step(8'h00);
      step(8'h40);
      step(8'h80);

      // Random traffic with an asynchronous reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         r = $urandom;
         step({r[0], (r[9:5] == 5'd0), (r[14:10] == 5'd0), r[1], r[19:16]});
      end
      step(8'h00);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/qspi_framebuffer_responder.md
# qspi_framebuffer_responder

Memory-side responder for the 8-bit framebuffer control bus driven by the VGA framebuffer reader and the Mandelbrot pixel writer. It decodes read, write and pointer-reset strobes and keeps independent read and write pointers into a 4-bit-wide pixel store. It returns one pixel nibble per read with one-cycle latency and repeats each stored source line LINE_REPEAT times. It replaces the external RP2040 QSPI RAM on FPGA builds and is the cycle-accurate bus model for system simulation.

## Interface
Parameters:
- DEPTH, 76800: pixel words stored (320 × 240).
- READS_PER_LINE, 320: read strobes per displayed line.
- LINE_REPEAT, 2: displayed lines per stored source line (≥1).
- ADDR_WIDTH, $clog2(DEPTH): pointer width.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ctrl_data_in  in  8  {read, reset_read_ptr, reset_write_ptr, write_data, write_data_in[3:0]}, bit 7 first.
- data_out  out  4  pixel nibble returned for the previous read.
- wr_addr_out  out  ADDR_WIDTH  current write pointer.
- rd_addr_out  out  ADDR_WIDTH  current read pointer.
- write_overflow_out  out  1  sticky: more than DEPTH writes since the last write-pointer reset.

## Operation
- Storage: DEPTH × 4-bit, one write port and one read port. Contents are not reset.
- Write detection:
  - A write occurs on the rising edge of write_data: write_data=1 in this cycle and write_prev=0.
  - write_prev is a register holding write_data from the previous cycle.
  - Holding write_data high performs one write only.
- Write: mem[wr_ptr] ← write_data_in, sampled in the edge cycle. wr_ptr ← wr_ptr+1, wrapping from DEPTH−1 to 0.
- reset_write_ptr=1:
  - wr_ptr ← 0; wr_full ← 0; write_overflow ← 0.
  - If a write edge occurs in the same cycle, the write goes to address 0 and wr_ptr ← 1.
- wr_full is set by the write to address DEPTH−1. A write while wr_full=1 sets write_overflow. The write is still performed at the wrapped address.
- Read: read=1 → data_out ← mem[rd_ptr] at the next edge, then the pointer update below.
- Line repeat uses three counters: line_start (address of the current source line's first pixel), read_cnt in 0..READS_PER_LINE−1 and rep_cnt in 0..LINE_REPEAT−1.
  - On a read with read_cnt < READS_PER_LINE−1: rd_ptr+1, read_cnt+1.
  - On a read with read_cnt = READS_PER_LINE−1 and rep_cnt < LINE_REPEAT−1: rd_ptr ← line_start, read_cnt ← 0, rep_cnt+1.
  - On a read with read_cnt = READS_PER_LINE−1 and rep_cnt = LINE_REPEAT−1: rd_ptr ← rd_ptr+1 and line_start ← rd_ptr+1 (both wrap at DEPTH), read_cnt ← 0, rep_cnt ← 0.
- reset_read_ptr=1: rd_ptr, line_start, read_cnt and rep_cnt all ← 0.
  - A simultaneous read returns mem[0]; the pointer then advances from 0 per the rules above (rd_ptr=1, read_cnt=1).
- A read and a write to the same address in the same cycle return the old contents (read-before-write).
- With no read, data_out holds its value.
- Bits ignored: write_data_in when there is no write edge; the ctrl bus in reset.

## Timing
- Reset (async assert, sync release) forces:
  - data_out=0, wr_addr_out=0, rd_addr_out=0, write_overflow_out=0.
  - write_prev=0, wr_full=0, line_start=0, read_cnt=0, rep_cnt=0.
- Read latency is 1 cycle: read high in cycle N → data_out valid from the edge ending cycle N through cycle N+1 at least. The requester samples data_out in cycle N+1.
- Back-to-back reads every cycle are supported at full rate. The display paces reads to every second cycle.
- Writes:
  - The write commits at the edge ending the edge-detect cycle; wr_addr_out updates at the same edge.
  - Minimum write period is 2 cycles (high, then low), because each write needs a fresh rising edge of write_data.
- Pointer outputs come directly from registers; no combinational path from ctrl_data_in to any output.
- write_overflow_out rises at the edge ending the offending write cycle.

## Test plan
- Reset: assert rst_n=0 mid-burst of reads and writes → all outputs 0 asynchronously. After release, the first read of address 0 returns the previously stored nibble (contents preserved).
- Write/read-back: reset_write_ptr, write 0x1..0xF to addresses 0..14 with 2-cycle strobes, reset_read_ptr, read 15 times → data_out sequence 0x1..0xF, each valid one cycle after its read.
- Held strobe: write_data held high 5 cycles with data 0xA → exactly one write; wr_addr_out increments by 1.
- Line repeat with READS_PER_LINE=4, LINE_REPEAT=2, memory 0..7 = 0..7 → 16 reads return 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7; rd_addr_out reaches 8.
- Overflow with DEPTH=8: 8 writes → write_overflow_out=0, wr_addr_out=0. 9th write → write_overflow_out=1 and address 0 is overwritten. reset_write_ptr → flag clears.
- Collisions:
  - reset_read_ptr together with read → returns mem[0], rd_addr_out=1.
  - Read and write to the same address in one cycle → old value returned, new value returned on the next pass.
